// File: rtl/rr_mux_arb_pkg.sv
// Shared constants and state type for the round-robin mux arbiter.
// The optional lock feature is enabled with the RR_MUX_ARB_LOCK_EN macro.
package rr_mux_arb_pkg;

   localparam int unsigned N_REQ      = 4;
   localparam int unsigned SEL_W      = 2;
   localparam int unsigned DATA_W_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/rr_mux_arb_pick.sv
// Circular first-one search over req_vld starting at ptr; yields a one-hot grant and its index.
module rr_mux_arb_pick
   import rr_mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req_vld,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] idx
);

   logic             found;
   logic [SEL_W-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         cand = ptr + SEL_W'(k);
         if (!found && req_vld[cand]) begin
            found     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin 4:1 mux arbiter with a one-word registered output stage.
// Define RR_MUX_ARB_LOCK_EN to add req_lock, which keeps a picked requester at top priority.
module rr_mux_arb
   import rr_mux_arb_pkg::*;
#(
   parameter int unsigned DATA_W = rr_mux_arb_pkg::DATA_W_DEF,
   parameter int unsigned N_REQ  = rr_mux_arb_pkg::N_REQ
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_vld,
   input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef RR_MUX_ARB_LOCK_EN
   input  logic [N_REQ-1:0]        req_lock,
`endif
   output logic [N_REQ-1:0]        req_rdy,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [DATA_W-1:0]       out_data,
   output logic [SEL_W-1:0]        sel
);

   state_t           state;
   state_t           state_nxt;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_nxt;
   logic [SEL_W-1:0] pick_idx;
   logic [N_REQ-1:0] pick_gnt;
   logic             cap_c;
   logic             hold_c;

   rr_mux_arb_pick u_pick (
      .req_vld (req_vld),
      .ptr     (ptr),
      .gnt     (pick_gnt),
      .idx     (pick_idx)
   );

   // A locked pick keeps the pointer on itself; otherwise priority moves past it.
`ifdef RR_MUX_ARB_LOCK_EN
   assign hold_c = req_lock[pick_idx];
`else
   assign hold_c = 1'b0;
`endif

   // Capture whenever the output slot is free or being drained this cycle; reset masks it.
   always_comb begin
      cap_c     = 1'b0;
      state_nxt = state;
      ptr_nxt   = ptr;
      if (rst_n && (|req_vld) && ((state == IDLE) || out_rdy)) begin
         cap_c = 1'b1;
      end
      case (state)
         IDLE:    if (cap_c) state_nxt = BUSY;
         BUSY:    if (out_rdy && !cap_c) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (cap_c) begin
         ptr_nxt = hold_c ? pick_idx : pick_idx + SEL_W'(1);
      end
   end

   assign req_rdy = cap_c ? pick_gnt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         out_vld  <= 1'b0;
         out_data <= '0;
         sel      <= '0;
         ptr      <= '0;
      end else begin
         state   <= state_nxt;
         out_vld <= (state_nxt == BUSY);
         ptr     <= ptr_nxt;
         if (cap_c) begin
            out_data <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
            sel      <= pick_idx;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb: directed scenarios plus random traffic against a reference model.
`timescale 1ns/1ps
module tb_rr_mux_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_vld;
   logic [15:0] req_data;
   logic [3:0]  req_lock;
   logic [3:0]  req_rdy;
   logic        out_vld;
   logic        out_rdy;
   logic [3:0]  out_data;
   logic [1:0]  sel;

   int checks = 0;
   int errors = 0;

   // Reference model: output slot occupancy, held word, and round-robin pointer.
   bit         m_busy;
   int         m_ptr;
   int         m_sel;
   logic [3:0] m_data;

   always #5 clk = ~clk;

   rr_mux_arb #(.DATA_W(4), .N_REQ(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_vld  (req_vld),
      .req_data (req_data),
`ifdef RR_MUX_ARB_LOCK_EN
      .req_lock (req_lock),
`endif
      .req_rdy  (req_rdy),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .sel      (sel)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_ptr  = 0;
      m_sel  = 0;
      m_data = 4'h0;
   endtask

   // One clock of traffic: drive, check the grant strobe, clock, check the registered outputs.
   task automatic step(input logic [3:0] v, input logic [15:0] d, input logic r, input logic [3:0] lk);
      int         pick;
      bit         cap;
      logic [3:0] exp_rdy;
      req_vld  = v;
      req_data = d;
      out_rdy  = r;
      req_lock = lk;
      #1;
      pick = -1;
      for (int k = 0; k < 4; k++) begin
         if (pick < 0 && v[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      end
      cap     = (!m_busy || r) && (pick >= 0);
      exp_rdy = cap ? 4'(1 << pick) : 4'b0000;
      check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
      @(posedge clk);
      if (cap) begin
         m_busy = 1'b1;
         m_sel  = pick;
         m_data = d[pick*4 +: 4];
         m_ptr  = lk[pick] ? pick : (pick + 1) % 4;
      end else if (r) begin
         m_busy = 1'b0;
      end
      #1;
      check("out_vld", 32'(out_vld), 32'(m_busy));
      check("out_data", 32'(out_data), 32'(m_data));
      check("sel", 32'(sel), 32'(m_sel));
   endtask

   initial begin
      rst_n    = 1'b0;
      req_vld  = 4'hF;
      req_data = 16'h4321;
      req_lock = 4'h0;
      out_rdy  = 1'b1;
      model_reset();
      #1;
      check("rst_out_vld", 32'(out_vld), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_req_rdy", 32'(req_rdy), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef RR_MUX_ARB_LOCK_EN
      // Locked requester 0 keeps winning until its lock drops.
      for (int i = 0; i < 3; i++) begin
         step(4'b0011, 16'h0021, 1'b1, 4'b0001);
         check("lock_sel0", 32'(sel), 32'd0);
      end
      step(4'b0011, 16'h0021, 1'b1, 4'b0000);
      check("lock_release_sel0", 32'(sel), 32'd0);
      step(4'b0011, 16'h0021, 1'b1, 4'b0000);
      check("lock_after_sel1", 32'(sel), 32'd1);
`endif

      // Drain to IDLE, then a single request held under backpressure.
      step(4'b0000, 16'h0000, 1'b1, 4'h0);
      check("drain_idle", 32'(out_vld), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(4'b0100, 16'h0A00, 1'b0, 4'h0);
         check("hold_data", 32'(out_data), 32'hA);
         check("hold_sel", 32'(sel), 32'd2);
      end

      // Pointer now at 3: requester 3 wins before wrapping to 0.
      step(4'b1001, 16'h7006, 1'b1, 4'h0);
      check("wrap_first", 32'(sel), 32'd3);
      step(4'b1001, 16'h7006, 1'b1, 4'h0);
      check("wrap_second", 32'(sel), 32'd0);

      // Toggling downstream ready with one steady requester.
      for (int i = 0; i < 8; i++) begin
         step(4'b0010, 16'(16'h0010 * (i + 1)), 1'(i % 2 == 0), 4'h0);
      end

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] lk;
         lk = 4'h0;
`ifdef RR_MUX_ARB_LOCK_EN
         lk = 4'($urandom_range(0, 15));
`endif
         step(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)), lk);
      end

      // Reset in the middle of a held word.
      step(4'b0000, 16'h0000, 1'b1, 4'h0);
      step(4'b0100, 16'h0500, 1'b0, 4'h0);
      check("pre_rst_data", 32'(out_data), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_vld", 32'(out_vld), 32'd0);
      check("async_rst_data", 32'(out_data), 32'd0);
      check("async_rst_sel", 32'(sel), 32'd0);
      check("async_rst_rdy", 32'(req_rdy), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("post_rst_vld", 32'(out_vld), 32'd0);

      // Full request set after reset: strict rotation from requester 0.
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 16'h4321, 1'b1, 4'h0);
         check("rotate_sel", 32'(sel), 32'(i % 4));
         check("rotate_data", 32'(out_data), 32'((i % 4) + 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning the per-requester data width.
REQ-002 SHALL have parameter N_REQ, default 4, meaning the number of requesters; only 4 is supported, giving a 2-bit select.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_vld  input  N_REQ  per-requester data valid.
REQ-006 SHALL have port req_data  input  N_REQ*DATA_W  packed requester data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port req_rdy  output  N_REQ  one-hot acceptance strobe.
REQ-008 SHALL have port out_vld  output  1  registered output valid.
REQ-009 SHALL have port out_rdy  input  1  downstream ready.
REQ-010 SHALL have port out_data  output  DATA_W  registered selected data.
REQ-011 SHALL have port sel  output  2  index of the requester whose data is held in out_data.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (out_vld=0) and BUSY (out_vld=1).
REQ-013 SHALL define the capture condition as cap = (IDLE or (BUSY and out_rdy)) and |req_vld.
REQ-014 SHALL, on cap, pick the first requester with req_vld set, searching circularly from ptr; latch its data into out_data and its index into sel; enter or stay in BUSY.
REQ-015 SHALL drive req_rdy[i]=1 combinationally only for the picked requester i in a cap cycle, and 0 for every other requester.
REQ-016 SHALL give one-cycle latency: req_vld sampled at edge N produces out_vld=1 after edge N.
REQ-017 SHALL hold out_data and sel stable while out_vld=1 and out_rdy=0.
REQ-018 SHALL return from BUSY to IDLE when out_rdy=1 and there is no req_vld.
REQ-019 SHALL sustain back-to-back transfers, one per cycle, when out_rdy and some req_vld are continuously high.
REQ-020 SHALL advance ptr to (picked+1) mod 4 on every cap; wrap 3->0.
REQ-021 SHALL ignore req_data of requesters that are not picked; a requester deasserting req_vld without req_rdy is legal and loses nothing.

Reset
REQ-022 SHALL, on rst_n low and asynchronously, force FSM=IDLE, out_vld=0, out_data=0, sel=0, ptr=0, lock state clear.
REQ-023 SHALL drive req_rdy=0 while rst_n is low.
REQ-024 SHALL discard a pending BUSY word if reset occurs mid-transfer; it is not replayed.

Configuration
REQ-025 SHALL, when RR_MUX_ARB_LOCK_EN is defined, add input req_lock (N_REQ).
REQ-026 SHALL, with the lock feature compiled in, leave ptr unadvanced when the picked requester has req_lock=1, so it keeps top priority.
REQ-027 SHALL, with the lock feature compiled in, release the lock on the first cap where that requester is picked with req_lock=0, or where it has req_vld=0.
REQ-028 SHALL, when RR_MUX_ARB_LOCK_EN is undefined, omit the req_lock port and always advance ptr per REQ-020.

Structure
REQ-029 SHALL place N_REQ, SEL_W=2, DATA_W default and the state enum {IDLE, BUSY} in package rr_mux_arb_pkg.
REQ-030 SHALL implement the circular first-one search as combinational sub-module rr_mux_arb_pick, with inputs req_vld and ptr and outputs a one-hot grant and an index.

Verification
REQ-031 SHALL cover: req_vld=4'b1111, data 1/2/3/4, out_rdy=1 -> sel 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4.
REQ-032 SHALL cover: req_vld=4'b0100, data 4'hA, out_rdy=0 for 3 cycles -> out_vld=1, out_data=A, sel=2 held stable; req_rdy pulses only in the first cycle.
REQ-033 SHALL cover: ptr=3 and req_vld=4'b1001 -> requester 3 is granted first, then requester 0 (wrap).
REQ-034 SHALL cover: rst_n low while BUSY with out_data=5 -> out_vld=0, out_data=0, sel=0 immediately without a clock; after release, ptr=0 priority applies.
REQ-035 SHALL cover: RR_MUX_ARB_LOCK_EN defined, req_vld=4'b0011, req_lock=4'b0001 for 3 captures -> sel=0 three times, then sel=1 after the lock clears.
REQ-036 SHALL cover: out_rdy toggling 1/0 with req_vld=4'b0010 constant -> exactly one req_rdy pulse per accepted output word; no word is lost or duplicated.
